// File: rtl/timer_bus_master.sv
// Bus-master sequencer that programs the timer slave, polls it idle, starts it,
// waits for its interrupt, then reads the count back and clears the interrupt.
module timer_bus_master #(
    parameter int POLL_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cfg_load_addr,
    input  logic       cfg_cnt_con,
    output logic       M_req,
    input  logic       M_grant,
    output logic       M_sel,
    output logic [7:0] M_address,
    output logic       M_wr,
    output logic [7:0] M_dout,
    input  logic [7:0] M_din,
    input  logic       interrupt,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] count_value,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        IDLE, REQ1, WR_LADDR, WR_CON, RD_STAT, RD_STAT_W, WR_EN,
        WAIT_INT, REQ2, RD_CNT, RD_CNT_W, WR_CLR, FIN
    } state_t;

    localparam logic [3:0] POLL_LAST = 4'(POLL_MAX - 1);

    state_t     state, state_nxt;
    logic [7:0] laddr_q;
    logic       con_q;
    logic [3:0] poll_cnt;
    logic       poll_last;
    logic       bus_act;
    logic [7:0] bus_addr;
    logic       bus_wr;
    logic [7:0] bus_data;

    assign poll_last = (poll_cnt >= POLL_LAST);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Bus-access states only advance on a granted cycle, so a lost grant
    // simply replays the same access once the grant returns.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start)     state_nxt = REQ1;
            REQ1:      if (M_grant)   state_nxt = WR_LADDR;
            WR_LADDR:  if (M_grant)   state_nxt = WR_CON;
            WR_CON:    if (M_grant)   state_nxt = RD_STAT;
            RD_STAT:   if (M_grant)   state_nxt = RD_STAT_W;
            RD_STAT_W: begin
                if (M_din == 8'h00)   state_nxt = WR_EN;
                else if (poll_last)   state_nxt = FIN;
                else                  state_nxt = RD_STAT;
            end
            WR_EN:     if (M_grant)   state_nxt = WAIT_INT;
            WAIT_INT:  if (interrupt) state_nxt = REQ2;
            REQ2:      if (M_grant)   state_nxt = RD_CNT;
            RD_CNT:    if (M_grant)   state_nxt = RD_CNT_W;
            RD_CNT_W:                 state_nxt = WR_CLR;
            WR_CLR:    if (M_grant)   state_nxt = FIN;
            FIN:                      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_act  = 1'b0;
        bus_addr = 8'h00;
        bus_wr   = 1'b0;
        bus_data = 8'h00;
        M_req    = 1'b0;
        busy     = (state != IDLE);
        done     = (state == FIN);
        case (state)
            REQ1, REQ2, RD_STAT_W, RD_CNT_W: M_req = 1'b1;
            WR_LADDR: begin M_req = 1'b1; bus_act = 1'b1; bus_addr = 8'h23; bus_wr = 1'b1; bus_data = laddr_q; end
            WR_CON:   begin M_req = 1'b1; bus_act = 1'b1; bus_addr = 8'h22; bus_wr = 1'b1; bus_data = {7'b0, con_q}; end
            RD_STAT:  begin M_req = 1'b1; bus_act = 1'b1; bus_addr = 8'h26; end
            WR_EN:    begin M_req = 1'b1; bus_act = 1'b1; bus_addr = 8'h20; bus_wr = 1'b1; bus_data = 8'h01; end
            RD_CNT:   begin M_req = 1'b1; bus_act = 1'b1; bus_addr = 8'h25; end
            WR_CLR:   begin M_req = 1'b1; bus_act = 1'b1; bus_addr = 8'h21; bus_wr = 1'b1; bus_data = 8'h00; end
            default:  ;
        endcase
        // Without the grant the bus is left fully quiet.
        M_sel     = bus_act & M_grant;
        M_address = M_sel ? bus_addr : 8'h00;
        M_wr      = M_sel & bus_wr;
        M_dout    = M_sel ? bus_data : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            laddr_q     <= 8'h00;
            con_q       <= 1'b0;
            poll_cnt    <= 4'd0;
            error       <= 1'b0;
            count_value <= 8'h00;
        end else begin
            if (state == IDLE && start) begin
                laddr_q  <= cfg_load_addr;
                con_q    <= cfg_cnt_con;
                poll_cnt <= 4'd0;
                error    <= 1'b0;
            end
            if (state == RD_STAT_W && M_din != 8'h00) begin
                poll_cnt <= (poll_cnt == 4'hF) ? poll_cnt : poll_cnt + 4'd1;
                if (poll_last) error <= 1'b1;
            end
            if (state == RD_CNT_W) count_value <= M_din;
        end
    end

endmodule

// File: tb/tb_timer_bus_master.sv
// Bench for timer_bus_master: a behavioural timer slave plus an arithmetic
// model of the expected bus traffic and completion timing.
module tb_timer_bus_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] cfg_load_addr;
  logic       cfg_cnt_con;
  logic       M_req;
  logic       M_grant = 1'b1;
  logic       M_sel;
  logic [7:0] M_address;
  logic       M_wr;
  logic [7:0] M_dout;
  logic [7:0] M_din = 8'h00;
  logic       interrupt = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] count_value;
  logic [3:0] dbg_state;

  timer_bus_master #(.POLL_MAX(15)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_load_addr(cfg_load_addr), .cfg_cnt_con(cfg_cnt_con),
    .M_req(M_req), .M_grant(M_grant), .M_sel(M_sel), .M_address(M_address),
    .M_wr(M_wr), .M_dout(M_dout), .M_din(M_din), .interrupt(interrupt),
    .busy(busy), .done(done), .error(error), .count_value(count_value),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Environment knobs, written only by the main sequence.
  int         e0 = 0;
  int         arm_seq = 0;
  int         int_cyc = 1000;
  bit         int_en = 1'b0;
  bit         gl_en = 1'b0;
  int         nz_reads = 0;
  logic [7:0] nz_val = 8'h00;
  logic [7:0] cnt_val = 8'h00;

  // Environment state, written only by the env process.
  int          edge_cnt = 0;
  int          env_cyc = 0;
  int          last_arm = 0;
  bit          cleared = 1'b0;
  int          rd26 = 0;
  bit          pend = 1'b0;
  logic [7:0]  pend_val = 8'h00;
  logic [16:0] obs_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          req_low = 0;
  int          sel_ng = 0;
  int          stall_cnt = 0;

  int          checks = 0;
  int          failures = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  last_cnt = 8'h00;

  // Timer slave + arbiter model: drives inputs just after the rising edge,
  // observes the bus mid-cycle.
  always begin
    @(posedge clk);
    #1;
    edge_cnt++;
    env_cyc = edge_cnt - e0 + 1;
    if (arm_seq != last_arm) begin
      last_arm = arm_seq;
      rd26 = 0;
      cleared = 1'b0;
    end
    if (pend) begin
      M_din = pend_val;
      pend = 1'b0;
    end
    M_grant = !(gl_en && env_cyc >= 3 && env_cyc <= 5);
    interrupt = int_en && !cleared && (env_cyc >= int_cyc);
    @(negedge clk);
    env_cyc = edge_cnt - e0 + 1;
    if (M_sel) begin
      obs_q.push_back({M_wr, M_address, M_dout});
      if (!M_wr) begin
        pend = 1'b1;
        if (M_address == 8'h26) begin
          pend_val = (rd26 < nz_reads) ? nz_val : 8'h00;
          rd26++;
        end else if (M_address == 8'h25) begin
          pend_val = cnt_val;
        end else begin
          pend_val = 8'h00;
        end
      end else if (M_address == 8'h21) begin
        cleared = 1'b1;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = env_cyc;
    end
    if (busy && !M_req) req_low++;
    if (M_sel && !M_grant) sel_ng++;
    if (M_req && !M_grant) stall_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req", {31'b0, M_req}, 0);
    check("rst_sel", {31'b0, M_sel}, 0);
    check("rst_addr", {24'b0, M_address}, 0);
    check("rst_wr", {31'b0, M_wr}, 0);
    check("rst_dout", {24'b0, M_dout}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_error", {31'b0, error}, 0);
    check("rst_count", {24'b0, count_value}, 0);
  endtask

  task automatic run_seq(input logic [7:0] la, input logic con, input int nz,
                         input logic [7:0] nzv, input logic [7:0] cv, input int ic,
                         input bit gl, input bit extra);
    int  base, rl0, sg0, st0, dc0, stall, we, n, done_exp, rl_exp, nreads;
    bit  err;
    err = (nz >= 15);
    stall = gl ? 3 : 0;
    nreads = err ? 15 : nz + 1;
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h23, la});
    exp_q.push_back({1'b1, 8'h22, 7'b0, con});
    for (int i = 0; i < nreads; i++) exp_q.push_back({1'b0, 8'h26, 8'h00});
    if (!err) begin
      exp_q.push_back({1'b1, 8'h20, 8'h01});
      exp_q.push_back({1'b0, 8'h25, 8'h00});
      exp_q.push_back({1'b1, 8'h21, 8'h00});
    end
    // Completion timing from the documented cycle budget.
    we = 7 + 2 * nz + stall;
    n = (ic > we) ? ic : we;
    if (err) begin
      done_exp = 4 + 2 * 14 + 2 + stall;
      rl_exp = 1;
    end else begin
      done_exp = n + 5;
      rl_exp = n - we + 2;
      last_cnt = cv;
    end

    @(negedge clk);
    int_en = 1'b0;
    gl_en = 1'b0;
    start = 1'b1;
    cfg_load_addr = la;
    cfg_cnt_con = con;
    nz_reads = nz;
    nz_val = nzv;
    cnt_val = cv;
    #2;
    base = obs_q.size();
    rl0 = req_low;
    sg0 = sel_ng;
    st0 = stall_cnt;
    dc0 = done_cnt;
    check("busy_before_start", {31'b0, busy}, 0);
    @(negedge clk);
    start = 1'b0;
    cfg_load_addr = $urandom;
    cfg_cnt_con = $urandom;
    e0 = edge_cnt;
    int_cyc = ic;
    gl_en = gl;
    int_en = 1'b1;
    arm_seq++;
    #2;
    check("busy_after_start", {31'b0, busy}, 1);
    for (int i = 0; i < 300 && done_cnt == dc0; i++) begin
      @(negedge clk);
      start = extra && ((edge_cnt - e0 + 1) == 10);
      #2;
    end
    start = 1'b0;
    check("done_seen", done_cnt - dc0, 1);
    check("done_cycle", done_cyc, done_exp);
    check("error", {31'b0, error}, {31'b0, err});
    check("count_value", {24'b0, count_value}, {24'b0, last_cnt});
    check("txn_count", obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
      check("bus_txn", {15'b0, obs_q[base + i]}, {15'b0, exp_q[i]});
    check("req_low_cycles", req_low - rl0, rl_exp);
    check("sel_without_grant", sel_ng - sg0, 0);
    check("stall_cycles", stall_cnt - st0, stall);
    @(negedge clk);
    #2;
    check("busy_after_fin", {31'b0, busy}, 0);
    check("done_after_fin", {31'b0, done}, 0);
    if (extra) begin
      repeat (20) @(negedge clk);
      #2;
      check("no_second_seq", obs_q.size() - base, exp_q.size());
      check("idle_after_extra", {31'b0, busy}, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfg_load_addr = 8'h00;
    cfg_cnt_con = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // Nominal
    run_seq(8'h40, 1'b0, 0, 8'h00, 8'h00, 20, 1'b0, 1'b0);
    // Poll retry
    run_seq(8'h5A, 1'b1, 2, 8'h06, 8'h9C, 15, 1'b0, 1'b0);
    // Poll limit, count_value must survive
    run_seq(8'h11, 1'b0, 99, 8'h08, 8'hEE, 20, 1'b0, 1'b0);
    // Grant loss during WR_CON
    run_seq(8'h77, 1'b1, 0, 8'h00, 8'h3C, 18, 1'b1, 1'b0);
    // Interrupt already pending on entry to WAIT_INT
    run_seq(8'hA5, 1'b0, 1, 8'h01, 8'h42, 3, 1'b0, 1'b0);
    // start while busy
    run_seq(8'h21, 1'b1, 0, 8'h00, 8'h5D, 14, 1'b0, 1'b1);

    // Reset while parked in WAIT_INT
    @(negedge clk);
    start = 1'b1;
    cfg_load_addr = 8'h33;
    cfg_cnt_con = 1'b0;
    nz_reads = 0;
    @(negedge clk);
    start = 1'b0;
    e0 = edge_cnt;
    int_cyc = 1000;
    int_en = 1'b0;
    gl_en = 1'b0;
    arm_seq++;
    repeat (9) @(negedge clk);
    #2;
    check("in_wait_int_req", {31'b0, M_req}, 0);
    check("in_wait_int_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    last_cnt = 8'h00;
    run_seq(8'h12, 1'b1, 0, 8'h00, 8'h81, 16, 1'b0, 1'b0);

    // Randomized sequences
    for (int k = 0; k < 4; k++)
      run_seq(8'($urandom), 1'($urandom), $urandom_range(0, 4), 8'($urandom_range(1, 255)),
              8'($urandom), $urandom_range(2, 30), 1'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_bus_master.md
# timer_bus_master

Bus-master sequencer for the timer register slave. On a `start` pulse it does four things over the shared slave bus:
- programs `LOAD_ADDRESS` (0x23) and `CNT_CON` (0x22);
- polls the timer `STATE` register (0x26) until idle, then starts the count through 0x20;
- releases the bus and waits for the timer `interrupt`;
- reads `COUNT_VALUE` (0x25) and clears the interrupt (write 0x00 to 0x21).

It sits between the system controller and the bus arbiter, in place of a CPU driving the timer.

## Interface
- `POLL_MAX`, 15: maximum number of 0x26 status reads before the block gives up with `error`.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request. Sampled only in IDLE.
- `cfg_load_addr` input 8: value written to 0x23. Captured when `start` is accepted.
- `cfg_cnt_con` input 1: value written to 0x22 (00h or 01h). Captured when `start` is accepted.
- `M_req` output 1: bus request to the arbiter.
- `M_grant` input 1: bus grant from the arbiter.
- `M_sel` output 1: slave select. Drives `S_sel`.
- `M_address` output 8: drives `S_address`.
- `M_wr` output 1: 1 = write, 0 = read. Drives `S_wr`.
- `M_dout` output 8: write data. Drives `S_din`.
- `M_din` input 8: read data from `S_dout`. The slave registers it, so it is valid the cycle after the address phase.
- `interrupt` input 1: timer interrupt, level.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a sequence ends, whether OK or error.
- `error` output 1: status of the last sequence; 1 = poll limit hit. Held until the next accepted `start`.
- `count_value` output 8: `COUNT_VALUE` read back by the last successful sequence.

## Operation
FSM states: IDLE, REQ1, WR_LADDR, WR_CON, RD_STAT, RD_STAT_W, WR_EN, WAIT_INT, REQ2, RD_CNT, RD_CNT_W, WR_CLR, FIN.

**Transitions**
- IDLE, `start`=1: capture the config, clear `error` and the poll counter, go to REQ1.
- REQ1 / REQ2: `M_req`=1. Go to the next bus state when `M_grant`=1; otherwise stay.
- WR_LADDR: write 0x23 = `cfg_load_addr`.
- WR_CON: write 0x22 = {7'b0, `cfg_cnt_con`}.
- RD_STAT: read 0x26, then RD_STAT_W.
- RD_STAT_W: bus idle; sample `M_din`.
  - `M_din`=00h: go to WR_EN.
  - Otherwise, poll counter +1. Go to RD_STAT, or to FIN with `error` set once `POLL_MAX` reads have returned nonzero.
- WR_EN: write 0x20 = 01h.
- WAIT_INT: `M_req`=0. Go to REQ2 when `interrupt`=1.
- RD_CNT: read 0x25. RD_CNT_W: load `count_value` from `M_din`.
- WR_CLR: write 0x21 = 00h.
- FIN: `done`=1, go to IDLE.

**Bus drive**
- Outputs are a Moore decode of the state.
- A bus cycle drives `M_sel`=1 with its address, `wr` and data. The slave acts at the closing edge.
- In all other states `M_sel`, `M_address`, `M_wr` and `M_dout` are 0.

**Request and grant**
- `M_req` is 1 from REQ1 through WR_EN and from REQ2 through WR_CLR; 0 elsewhere.
- If `M_grant` drops while `M_req`=1, the block stays in its current state with `M_sel`=0 and reissues the same access when the grant returns. No access is skipped or repeated.

**Other rules**
- `start` while `busy` is ignored.
- `count_value` keeps its old value on an error sequence.
- The poll counter is 4 bits and saturates; it does not wrap.

## Timing
- Reset (asynchronous, any state): go to IDLE immediately. `M_req`, `M_sel`, `M_address`, `M_wr`, `M_dout`, `busy`, `done` and `error` = 0; `count_value` = 00h.
- Reset mid-transaction drops the bus at once. The slave state is not restored.
- Read latency: address in cycle k, data sampled at the end of cycle k+1.
- With `M_grant` tied to 1 and a first poll of 00h:
  - `start` accepted at edge 0.
  - REQ1 occupies cycle 1; WR_LADDR through WR_EN occupy cycles 2–6.
  - WAIT_INT starts in cycle 7.
  - With `interrupt` seen in cycle n: REQ2 in cycle n+1, RD_CNT, RD_CNT_W, WR_CLR, then FIN at cycle n+5.
- Each extra poll adds 2 cycles.
- `interrupt` already high on entry to WAIT_INT: WAIT_INT lasts one cycle.
- `busy` rises the cycle after `start` is accepted and falls the cycle after FIN.

## Test plan
- Nominal: `cfg_load_addr`=40h, `cfg_cnt_con`=0, grant tied 1, status 00h, `interrupt` at cycle 20, `M_din`=00h on the 0x25 read.
  - Bus sees W23=40, W22=00, R26, W20=01, R25, W21=00 in that order.
  - `count_value`=00h, `done` pulses at cycle 25, `error`=0.
- Poll retry: status returns 06h twice, then 00h.
  - Three 0x26 reads, then W20=01.
  - WR_EN is 4 cycles later than nominal.
- Poll limit: status stuck at 08h. Exactly 15 0x26 reads, no write to 0x20, `done`=1 with `error`=1, `count_value` unchanged.
- Grant loss: `M_grant` drops for 3 cycles during WR_CON.
  - `M_sel` is 0 for those cycles.
  - W22 is issued exactly once after the grant returns.
  - `M_req` is low for the whole WAIT_INT period.
- Reset during WAIT_INT: all outputs take their reset values at once. A following `start` with 12h, `cfg_cnt_con`=1 runs a full sequence with W22=01.
- `start` pulsed while busy: ignored; only one sequence is seen on the bus.
